// File: rtl/spi_master.sv
// spi_master: CPU-mapped SPI mode-0 master for an SD card; optional irq output via SPI_IRQ_EN
module spi_master #(
  parameter logic [7:0] DIV_RESET = 8'd24,
  parameter int         XFER_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       sd_cs,
  output logic       spi_clk,
  output logic       spi_mosi,
`ifdef SPI_IRQ_EN
  output logic       irq,
`endif
  input  logic       spi_miso
);
  localparam int BW = (XFER_BITS > 1) ? $clog2(XFER_BITS) : 1;
  localparam logic [BW-1:0] LAST = BW'(XFER_BITS - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  logic [1:0]    state;
  logic [7:0]    cnt, div, tx, rx, rx_data;
  logic [BW-1:0] bit_cnt;
  logic          done, cs_en, irq_en, busy, wr_data, rd_data, half_end, fin;
  assign busy     = state != IDLE;
  assign wr_data  = cs & we & (addr == 2'd0);
  assign rd_data  = cs & ~we & (addr == 2'd0);
  assign half_end = cnt == 8'd0;
  assign fin      = (state == HIGH) & half_end & (bit_cnt == LAST);
  assign spi_clk  = state == HIGH;
  assign spi_mosi = busy ? tx[7] : 1'b1;
  assign sd_cs    = ~cs_en;
  assign data_o   = addr == 2'd0 ? rx_data :
                    addr == 2'd1 ? {busy, done, 4'b0, irq_en, cs_en} :
                    addr == 2'd2 ? div : 8'h00;
`ifdef SPI_IRQ_EN
  assign irq = done & irq_en;
  // irq enable bit, written through CTRL bit1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) irq_en <= 1'b0;
    else if (cs & we & (addr == 2'd1)) irq_en <= data_i[1];
`else
  assign irq_en = 1'b0;
`endif
  // CTRL and DIV registers; a DIV change is picked up when the next half-period loads cnt
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cs_en <= 1'b0;
      div   <= DIV_RESET;
    end else begin
      if (cs & we & (addr == 2'd1)) cs_en <= data_i[0];
      if (cs & we & (addr == 2'd2)) div <= data_i;
    end
  // done flag: set by the last HIGH phase ending, cleared by a DATA read, set wins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) done <= 1'b0;
    else done <= fin | (done & ~rd_data);
  // transfer FSM: cnt counts down each half-period, miso sampled on entry to HIGH
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_cnt <= '0;
      tx      <= 8'hff;
      rx      <= 8'h00;
      rx_data <= 8'h00;
    end else if (state == IDLE) begin
      if (wr_data) begin
        state   <= LOW;
        cnt     <= div;
        bit_cnt <= '0;
        tx      <= data_i;
      end
    end else if (!half_end) cnt <= cnt - 8'd1;
    else if (state == LOW) begin
      state <= HIGH;
      cnt   <= div;
      rx    <= {rx[6:0], spi_miso};
    end else if (fin) begin
      state   <= IDLE;
      rx_data <= rx;
    end else begin
      state   <= LOW;
      cnt     <= div;
      bit_cnt <= bit_cnt + 1'b1;
      tx      <= {tx[6:0], 1'b1};
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master covering timing, loopback, drop, reset and CTRL
module tb_spi_master;
  logic       clk = 0, rst_n = 0, cs = 0, we = 0, loop = 0, miso_val = 0;
  logic [1:0] addr = 0;
  logic [7:0] data_i = 0;
  logic [7:0] data_o;
  logic       sd_cs, spi_clk, spi_mosi, spi_miso;
`ifdef SPI_IRQ_EN
  logic       irq;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  assign spi_miso = loop ? spi_mosi : miso_val;
  always #5 clk = ~clk;
  spi_master dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .data_i(data_i), .data_o(data_o),
    .sd_cs(sd_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
`ifdef SPI_IRQ_EN
    .irq(irq),
`endif
    .spi_miso(spi_miso)
  );
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1; we = 1; addr = a; data_i = d;
    @(negedge clk);
    cs = 0; we = 0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    cs = 1; we = 0; addr = a;
    #1 d = data_o;
    @(negedge clk);
    cs = 0;
  endtask
  // starts a transfer and watches STATUS.busy and spi_clk every cycle until busy falls
  task automatic xfer(input logic [7:0] d, input int half, input logic [7:0] exp_rx,
                      output int cyc, output int rises, output int bad_runs,
                      output logic [7:0] sh, output logic done_at_fall);
    logic pc;
    int run;
    exp_q.push_back(exp_rx);
    wr(2'd0, d);
    cyc = 0; rises = 0; bad_runs = 0; sh = 0; pc = 0; run = 0;
    cs = 1; we = 0; addr = 2'd1;
    #1;
    while (data_o[7] && cyc < 4000) begin
      cyc++;
      if (spi_clk != pc) begin
        if (run != half) bad_runs++;
        run = 0;
        if (spi_clk) begin
          rises++;
          sh = {sh[6:0], spi_mosi};
        end
      end
      run++;
      pc = spi_clk;
      @(negedge clk);
      #1;
    end
    if (run != half) bad_runs++;
    done_at_fall = data_o[6];
    cs = 0;
  endtask
  task automatic pop_check(input string name);
    logic [7:0] got, exp;
    rd(2'd0, got);
    exp = exp_q.size() ? exp_q.pop_front() : 8'hxx;
    n_cmp++;
    if (got !== exp) begin n_bad++; $display("FAIL %s: got %h expected %h", name, got, exp); end
  endtask
  task automatic test_reset;
    logic [7:0] v;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sd_cs, spi_clk, spi_mosi} !== 3'b101) begin n_bad++; $display("FAIL reset_pins: got %b expected 101", {sd_cs, spi_clk, spi_mosi}); end
    rst_n = 1;
    rd(2'd2, v);
    n_cmp++;
    if (v !== 8'd24) begin n_bad++; $display("FAIL reset_div: got %h expected 18", v); end
    rd(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL reset_status: got %h expected 00", v); end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h expected 00", v); end
    wr(2'd3, 8'h5a);
    rd(2'd3, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL addr3: got %h expected 00", v); end
  endtask
  task automatic test_loopback;
    int cyc, rises, bad;
    logic [7:0] sh, v;
    logic dn;
    loop = 1;
    wr(2'd2, 8'd0);
    xfer(8'ha5, 1, 8'ha5, cyc, rises, bad, sh, dn);
    n_cmp++;
    if (cyc !== 16) begin n_bad++; $display("FAIL div0_busy: got %0d expected 16", cyc); end
    n_cmp++;
    if (bad !== 0 || sh !== 8'ha5) begin n_bad++; $display("FAIL div0_wave: bad_runs %0d mosi %h expected 0 a5", bad, sh); end
    n_cmp++;
    if (dn !== 1'b1) begin n_bad++; $display("FAIL done_at_fall: got %b expected 1", dn); end
    rd(2'd1, v);
    n_cmp++;
    if (v !== 8'h40) begin n_bad++; $display("FAIL status_done: got %h expected 40", v); end
    pop_check("div0_rx");
    rd(2'd1, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL done_clear: got %h expected 00", v); end
    xfer(8'h3c, 1, 8'h3c, cyc, rises, bad, sh, dn);
    pop_check("div0_rx2");
  endtask
  task automatic test_div3;
    int cyc, rises, bad;
    logic [7:0] sh;
    logic dn;
    loop = 0; miso_val = 0;
    wr(2'd2, 8'd3);
    xfer(8'hff, 4, 8'h00, cyc, rises, bad, sh, dn);
    n_cmp++;
    if (cyc !== 64) begin n_bad++; $display("FAIL div3_busy: got %0d expected 64", cyc); end
    n_cmp++;
    if (rises !== 8) begin n_bad++; $display("FAIL div3_rises: got %0d expected 8", rises); end
    n_cmp++;
    if (bad !== 0 || sh !== 8'hff) begin n_bad++; $display("FAIL div3_wave: bad_runs %0d mosi %h expected 0 ff", bad, sh); end
    pop_check("div3_rx");
  endtask
  task automatic test_back_to_back;
    int cyc, rises, bad;
    logic [7:0] sh;
    logic dn;
    loop = 1;
    wr(2'd2, 8'd1);
    exp_q.push_back(8'h11);
    wr(2'd0, 8'h11);
    wr(2'd0, 8'h22);
    cyc = 0; rises = 0; sh = 0; dn = 0;
    cs = 1; we = 0; addr = 2'd1;
    #1;
    while (data_o[7] && cyc < 4000) begin
      if (spi_clk && !dn) begin rises++; sh = {sh[6:0], spi_mosi}; end
      dn = spi_clk;
      cyc++;
      @(negedge clk);
      #1;
    end
    cs = 0;
    n_cmp++;
    if (sh !== 8'h11 || rises !== 8) begin n_bad++; $display("FAIL b2b_mosi: got %h/%0d expected 11/8", sh, rises); end
    n_cmp++;
    if (cyc !== 30) begin n_bad++; $display("FAIL b2b_busy: got %0d expected 30", cyc); end
    pop_check("b2b_rx");
    rd(2'd1, sh);
    n_cmp++;
    if (sh[7] !== 1'b0) begin n_bad++; $display("FAIL b2b_idle: got busy %b expected 0", sh[7]); end
  endtask
  task automatic test_cs;
    int cyc, rises, bad;
    logic [7:0] sh, v;
    logic dn;
    wr(2'd1, 8'h01);
    n_cmp++;
    if (sd_cs !== 1'b0) begin n_bad++; $display("FAIL sd_cs_on: got %b expected 0", sd_cs); end
    rd(2'd1, v);
    n_cmp++;
    if (v !== 8'h01) begin n_bad++; $display("FAIL status_idle: got %h expected 01", v); end
    loop = 1;
    exp_q.push_back(8'h96);
    wr(2'd0, 8'h96);
    rd(2'd1, v);
    n_cmp++;
    if (v !== 8'h81) begin n_bad++; $display("FAIL status_busy: got %h expected 81", v); end
    wr(2'd1, 8'h00);
    n_cmp++;
    if (sd_cs !== 1'b1) begin n_bad++; $display("FAIL sd_cs_mid: got %b expected 1", sd_cs); end
    cyc = 0;
    rd(2'd1, v);
    while (v[7] && cyc < 4000) begin rd(2'd1, v); cyc++; end
    n_cmp++;
    if (v !== 8'h40) begin n_bad++; $display("FAIL cs_no_abort: got %h expected 40", v); end
    pop_check("cs_rx");
`ifdef SPI_IRQ_EN
    wr(2'd1, 8'h03);
    xfer(8'h5c, 2, 8'h5c, cyc, rises, bad, sh, dn);
    n_cmp++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b expected 1", irq); end
    pop_check("irq_rx");
    n_cmp++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b expected 0", irq); end
    wr(2'd1, 8'h00);
`endif
  endtask
  task automatic test_reset_mid;
    int cyc;
    logic [7:0] v;
    logic pc;
    loop = 1;
    wr(2'd2, 8'd1);
    wr(2'd1, 8'h01);
    wr(2'd0, 8'hc3);
    cyc = 0; pc = 0; v = 0;
    while (v < 4 && cyc < 4000) begin
      if (spi_clk && !pc) v++;
      pc = spi_clk;
      cyc++;
      if (v < 4) @(negedge clk);
    end
    #1 rst_n = 0;
    cs = 1; we = 0; addr = 2'd1;
    #1;
    n_cmp++;
    if ({spi_clk, sd_cs, data_o[7]} !== 3'b010) begin n_bad++; $display("FAIL reset_mid: clk/sd_cs/busy %b expected 010", {spi_clk, sd_cs, data_o[7]}); end
    cs = 0;
    @(negedge clk);
    rst_n = 1;
    rd(2'd2, v);
    n_cmp++;
    if (v !== 8'd24) begin n_bad++; $display("FAIL reset_mid_div: got %h expected 18", v); end
    rd(2'd0, v);
    n_cmp++;
    if (v !== 8'h00) begin n_bad++; $display("FAIL reset_mid_rx: got %h expected 00", v); end
  endtask
  initial begin
    test_reset;
    test_loopback;
    test_div3;
    test_back_to_back;
    test_cs;
    test_reset_mid;
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_left: got %0d expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
